fifo_uart_tx: RTL and testbench

UART transmitter that drains the byte FIFO from its read side. Whenever the FIFO is non-empty, it pops one word and serializes it as an asynchronous 8N1-style frame on `tx`. It is the counterpart to the receive path that fills the FIFO, and pairs with the existing FIFO read port (`rd`, `empty`, `r_data`).

---
 rtl/uart_pkg.sv | 28 ++
 rtl/baud_tick_gen.sv | 43 ++++
 rtl/fifo_uart_tx.sv | 153 +++++++++++++++
 tb/tb_fifo_uart_tx.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Definitions shared by the UART transmit and receive paths:
//   - uart_state_e : frame FSM state encoding (IDLE/START/DATA/STOP)
//   - OS_TICKS     : oversample ticks per bit
//   - SB_TICK_*    : supported stop-bit lengths, in oversample ticks
//   - sb_tick_legal: true when a stop-bit length is one of the supported values
// -----------------------------------------------------------------------------
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        START = 2'b01,
        DATA  = 2'b10,
        STOP  = 2'b11
    } uart_state_e;

    localparam int OS_TICKS = 16;

    localparam int SB_TICK_1   = 16;  // 1 stop bit
    localparam int SB_TICK_1P5 = 24;  // 1.5 stop bits
    localparam int SB_TICK_2   = 32;  // 2 stop bits

    function automatic logic sb_tick_legal(input int sb_tick);
        return (sb_tick == SB_TICK_1) || (sb_tick == SB_TICK_1P5) || (sb_tick == SB_TICK_2);
    endfunction

endpackage

// File: rtl/baud_tick_gen.sv
// -----------------------------------------------------------------------------
// baud_tick_gen
// Oversample tick generator. The count runs 0..DVSR-1 and tick is high for the
// single cycle in which the count equals DVSR-1.
//   CLK   in  system clock
//   RESET in  asynchronous reset, active low
//   clr   in  holds the count at 0 while high
//   tick  out one-cycle oversample tick
// -----------------------------------------------------------------------------
module baud_tick_gen #(
    parameter int DVSR     = 163,
    parameter int DVSR_BIT = 8
) (
    input  logic CLK,
    input  logic RESET,
    input  logic clr,
    output logic tick
);

    logic [DVSR_BIT-1:0] count_q;
    logic [DVSR_BIT-1:0] count_d;

    assign tick = (count_q == DVSR_BIT'(DVSR - 1));

    always_comb begin
        if (clr || tick) begin
            count_d = '0;
        end else begin
            count_d = count_q + DVSR_BIT'(1);
        end
    end

    // NOTE: state registers use non-blocking assignment so every flop samples
    // the pre-edge value of its inputs, independent of process ordering.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/fifo_uart_tx.sv
// -----------------------------------------------------------------------------
// fifo_uart_tx
// UART transmitter draining a byte FIFO. When the FIFO is non-empty in IDLE it
// captures the head word, pulses fifo_rd once and sends one start bit, DBIT data
// bits LSB first and SB_TICK oversample ticks of stop level on tx.
//   CLK         in  system clock
//   RESET       in  asynchronous reset, active low
//   fifo_empty  in  FIFO empty flag (only looked at in IDLE)
//   fifo_r_data in  FIFO head word
//   fifo_rd     out one-cycle pop strobe, high in the first start-bit cycle
//   tx          out serial line, idles high, driven from a flop
//   tx_busy     out high while a frame is in progress
//   tx_done     out one-cycle pulse in the first IDLE cycle after a frame
// -----------------------------------------------------------------------------
module fifo_uart_tx
    import uart_pkg::*;
#(
    parameter int DBIT     = 8,
    parameter int SB_TICK  = 16,
    parameter int DVSR     = 163,
    parameter int DVSR_BIT = 8
) (
    input  logic            CLK,
    input  logic            RESET,
    input  logic            fifo_empty,
    input  logic [DBIT-1:0] fifo_r_data,
    output logic            fifo_rd,
    output logic            tx,
    output logic            tx_busy,
    output logic            tx_done
);

    localparam int NW = (DBIT > 1) ? $clog2(DBIT) : 1;

    uart_state_e     state_q, state_d;
    logic [4:0]      s_q, s_d;
    logic [NW-1:0]   n_q, n_d;
    logic [DBIT-1:0] shift_q, shift_d;
    logic            tx_q, tx_d;
    logic            rd_q, rd_d;
    logic            done_q, done_d;
    logic            tick;
    logic            baud_clr;

    // Holding the divider at 0 in IDLE aligns the first tick of every frame to
    // the capture edge, so each bit lasts exactly OS_TICKS*DVSR cycles.
    assign baud_clr = (state_q == IDLE);

    baud_tick_gen #(
        .DVSR     (DVSR),
        .DVSR_BIT (DVSR_BIT)
    ) u_baud_tick_gen (
        .CLK   (CLK),
        .RESET (RESET),
        .clr   (baud_clr),
        .tick  (tick)
    );

    // NOTE: every signal written here gets a default first, so no path leaves
    // a value unassigned and no latch is inferred.
    always_comb begin
        state_d = state_q;
        s_d     = s_q;
        n_d     = n_q;
        shift_d = shift_q;
        rd_d    = 1'b0;
        done_d  = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    shift_d = fifo_r_data;
                    s_d     = '0;
                    n_d     = '0;
                    rd_d    = 1'b1;
                    state_d = START;
                end
            end
            START: begin
                if (tick) begin
                    if (s_q == 5'(OS_TICKS - 1)) begin
                        s_d     = '0;
                        state_d = DATA;
                    end else begin
                        s_d = s_q + 5'd1;
                    end
                end
            end
            DATA: begin
                if (tick) begin
                    if (s_q == 5'(OS_TICKS - 1)) begin
                        s_d     = '0;
                        shift_d = shift_q >> 1;
                        if (n_q == NW'(DBIT - 1)) begin
                            state_d = STOP;
                        end else begin
                            n_d = n_q + NW'(1);
                        end
                    end else begin
                        s_d = s_q + 5'd1;
                    end
                end
            end
            STOP: begin
                if (tick) begin
                    if (s_q == 5'(SB_TICK - 1)) begin
                        s_d     = '0;
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end else begin
                        s_d = s_q + 5'd1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // tx is registered from the next state so the line changes on the same
        // edge as the state and never glitches.
        tx_d = 1'b1;
        unique case (state_d)
            START:   tx_d = 1'b0;
            DATA:    tx_d = shift_d[0];
            default: tx_d = 1'b1;
        endcase
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q <= IDLE;
            s_q     <= '0;
            n_q     <= '0;
            shift_q <= '0;
            tx_q    <= 1'b1;
            rd_q    <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            s_q     <= s_d;
            n_q     <= n_d;
            shift_q <= shift_d;
            tx_q    <= tx_d;
            rd_q    <= rd_d;
            done_q  <= done_d;
        end
    end

    assign fifo_rd = rd_q;
    assign tx      = tx_q;
    assign tx_done = done_q;
    assign tx_busy = (state_q != IDLE);

endmodule

// File: tb/tb_fifo_uart_tx.sv
// -----------------------------------------------------------------------------
// tb_fifo_uart_tx
// Two transmitters with DVSR=2, DBIT=8: dut_a with 1 stop bit (SB_TICK=16) and
// dut_b with 2 stop bits (SB_TICK=32). Bit time is 32 cycles. Frames are listed
// in a vector table with hand-computed line sequences (index 0 = start bit,
// 9 = stop bit); reset, back-to-back and fifo_empty-toggling cases are written
// out as sequences.
// -----------------------------------------------------------------------------
module tb_fifo_uart_tx;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       empty_a, empty_b;
    logic [7:0] data_a, data_b;
    logic       rd_a, tx_a, busy_a, done_a;
    logic       rd_b, tx_b, busy_b, done_b;

    fifo_uart_tx #(.DBIT(8), .SB_TICK(16), .DVSR(2), .DVSR_BIT(8)) dut_a (
        .CLK(clk), .RESET(rst), .fifo_empty(empty_a), .fifo_r_data(data_a),
        .fifo_rd(rd_a), .tx(tx_a), .tx_busy(busy_a), .tx_done(done_a)
    );

    fifo_uart_tx #(.DBIT(8), .SB_TICK(32), .DVSR(2), .DVSR_BIT(8)) dut_b (
        .CLK(clk), .RESET(rst), .fifo_empty(empty_b), .fifo_r_data(data_b),
        .fifo_rd(rd_b), .tx(tx_b), .tx_busy(busy_b), .tx_done(done_b)
    );

    // Selected-DUT view used by the frame checker.
    logic sel;
    logic tx_s, busy_s, done_s, rd_s;
    assign tx_s   = sel ? tx_b   : tx_a;
    assign busy_s = sel ? busy_b : busy_a;
    assign done_s = sel ? done_b : done_a;
    assign rd_s   = sel ? rd_b   : rd_a;

    int tests  = 0;
    int failed = 0;

    // Event monitors, sampled on the falling edge.
    int cyc = 0;
    int rd_cnt_a = 0, done_cnt_a = 0, rd_cnt_b = 0, done_cnt_b = 0;
    int last_rd_a = 0, prev_rd_a = 0;
    int run_a = 0, last_run_a = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rd_a === 1'b1) begin
            rd_cnt_a  <= rd_cnt_a + 1;
            prev_rd_a <= last_rd_a;
            last_rd_a <= cyc;
        end
        if (done_a === 1'b1) done_cnt_a <= done_cnt_a + 1;
        if (rd_b === 1'b1) rd_cnt_b <= rd_cnt_b + 1;
        if (done_b === 1'b1) done_cnt_b <= done_cnt_b + 1;
        if (tx_a === 1'b1) begin
            run_a <= run_a + 1;
        end else begin
            if (run_a != 0) last_run_a <= run_a;
            run_a <= 0;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Entered at the falling edge of the first start-bit cycle; leaves at the
    // falling edge of the tx_done cycle.
    task automatic check_frame(input string name, input logic [9:0] frame, input int stop_cyc);
        int bad;
        int ctl_bad;
        int len;
        ctl_bad = 0;
        check($sformatf("%s fifo_rd in first start cycle", name), rd_s, 1);
        for (int b = 0; b < 10; b++) begin
            len = (b == 9) ? stop_cyc : 32;
            bad = 0;
            for (int c = 0; c < len; c++) begin
                if (b != 0 || c != 0) begin
                    @(negedge clk);
                    if (rd_s !== 1'b0) ctl_bad++;
                end
                if (tx_s !== frame[b]) bad++;
                if (busy_s !== 1'b1 || done_s !== 1'b0) ctl_bad++;
            end
            check($sformatf("%s tx bit %0d wrong cycles", name, b), bad, 0);
        end
        check($sformatf("%s busy/done/rd bad cycles in frame", name), ctl_bad, 0);
        @(negedge clk);
        check($sformatf("%s tx_done after frame", name), done_s, 1);
        check($sformatf("%s tx_busy after frame", name), busy_s, 0);
        check($sformatf("%s tx idle after frame", name), tx_s, 1);
    endtask

    typedef struct {
        string      name;
        logic       sel;
        logic [7:0] data;
        logic [9:0] frame;
        int         stop_cyc;
    } vec_t;

    vec_t vecs[4];

    initial begin
        int bad;
        int rd0;
        int d0;

        // frame = {stop, data[7:0], start}, hand-expanded.
        vecs[0] = '{"a5",      1'b0, 8'hA5, 10'b1101001010, 32};
        vecs[1] = '{"3c_sb32", 1'b1, 8'h3C, 10'b1001111000, 64};
        vecs[2] = '{"81",      1'b0, 8'h81, 10'b1100000010, 32};
        vecs[3] = '{"3c",      1'b0, 8'h3C, 10'b1001111000, 32};

        rst     = 1'b0;
        sel     = 1'b0;
        empty_a = 1'b1;
        empty_b = 1'b1;
        data_a  = 8'h00;
        data_b  = 8'h00;

        // Reset values.
        repeat (3) @(negedge clk);
        check("reset tx_a", tx_a, 1);
        check("reset fifo_rd_a", rd_a, 0);
        check("reset tx_busy_a", busy_a, 0);
        check("reset tx_done_a", done_a, 0);
        check("reset tx_b", tx_b, 1);
        check("reset tx_busy_b", busy_b, 0);

        // Release with an empty FIFO: nothing may move.
        @(posedge clk); #1 rst = 1'b1;
        bad = 0;
        repeat (200) begin
            @(negedge clk);
            if (tx_a !== 1'b1 || tx_b !== 1'b1 || busy_a !== 1'b0 || busy_b !== 1'b0 ||
                done_a !== 1'b0 || done_b !== 1'b0 || rd_a !== 1'b0 || rd_b !== 1'b0) bad++;
        end
        check("idle after reset bad cycles", bad, 0);
        #1 check("idle after reset fifo_rd count", rd_cnt_a + rd_cnt_b, 0);

        // Single frames from the vector table.
        for (int i = 0; i < 4; i++) begin
            sel = vecs[i].sel;
            rd0 = sel ? rd_cnt_b : rd_cnt_a;
            @(posedge clk); #1;
            if (sel) begin data_b = vecs[i].data; empty_b = 1'b0; end
            else     begin data_a = vecs[i].data; empty_a = 1'b0; end
            @(posedge clk); #1;
            if (sel) begin empty_b = 1'b1; data_b = ~vecs[i].data; end
            else     begin empty_a = 1'b1; data_a = ~vecs[i].data; end
            @(negedge clk);
            check_frame(vecs[i].name, vecs[i].frame, vecs[i].stop_cyc);
            #1 check($sformatf("%s fifo_rd pulses", vecs[i].name),
                     (sel ? rd_cnt_b : rd_cnt_a) - rd0, 1);
            @(negedge clk);
            check($sformatf("%s tx_done single cycle", vecs[i].name), done_s, 0);
            repeat (5) @(negedge clk);
        end

        // Back-to-back 0x00 then 0xFF with the FIFO never empty in between.
        sel = 1'b0;
        @(posedge clk); #1 data_a = 8'h00; empty_a = 1'b0;
        @(posedge clk); #1 data_a = 8'hFF;
        @(negedge clk);
        check_frame("b2b 00", 10'b1000000000, 32);
        @(posedge clk); #1 empty_a = 1'b1; data_a = 8'h00;
        @(negedge clk);
        #1;
        check("b2b fifo_rd spacing", last_rd_a - prev_rd_a, 321);
        check("b2b line high between frames", last_run_a, 33);
        check_frame("b2b ff", 10'b1111111110, 32);
        repeat (5) @(negedge clk);

        // Reset in the middle of data bit 4 of 0xA5 (bit 4 is 0).
        rd0 = rd_cnt_a;
        @(posedge clk); #1 data_a = 8'hA5; empty_a = 1'b0;
        @(posedge clk); #1 empty_a = 1'b1;
        @(negedge clk);
        repeat (170) @(negedge clk);
        check("mid-frame tx before reset", tx_a, 0);
        check("mid-frame busy before reset", busy_a, 1);
        #1 rst = 1'b0;
        #1;
        check("async reset tx", tx_a, 1);
        check("async reset tx_busy", busy_a, 0);
        check("async reset fifo_rd", rd_a, 0);
        check("async reset tx_done", done_a, 0);
        rd0 = rd_cnt_a;
        d0  = done_cnt_a;
        @(posedge clk); #1 rst = 1'b1;
        bad = 0;
        repeat (400) begin
            @(negedge clk);
            if (tx_a !== 1'b1 || busy_a !== 1'b0) bad++;
        end
        check("after abort line/busy bad cycles", bad, 0);
        #1;
        check("after abort fifo_rd pulses", rd_cnt_a - rd0, 0);
        check("after abort tx_done pulses", done_cnt_a - d0, 0);

        // fifo_empty toggling every 7 cycles with changing data during a frame.
        rd0 = rd_cnt_a;
        d0  = done_cnt_a;
        @(posedge clk); #1 data_a = 8'hC3; empty_a = 1'b0;
        @(posedge clk); #1 empty_a = 1'b1; data_a = 8'h3C;
        @(negedge clk);
        fork
            check_frame("toggle c3", 10'b1110000110, 32);
            begin
                for (int i = 0; i < 300; i++) begin
                    @(posedge clk); #1;
                    if (i % 7 == 6) empty_a = ~empty_a;
                    data_a = 8'($urandom);
                end
                empty_a = 1'b1;
            end
        join
        #1;
        check("toggle fifo_rd pulses", rd_cnt_a - rd0, 1);
        check("toggle fifo_rd count vs tx_done count", rd_cnt_a - rd0, done_cnt_a - d0);
        repeat (5) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
